// File: rtl/core_sequencer.sv
// Run-control sequencer: loads an image into data memory, runs the core
// with a cycle budget, then streams the result region back out.
module core_sequencer #(
    parameter int LOAD_LEN   = 64,
    parameter int RES_BASE   = 64,
    parameter int RES_LEN    = 32,
    parameter int MAX_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        core_reset,
    input  logic        core_done,
    output logic        mem_sel,
    output logic        dm_wen,
    output logic [7:0]  dm_addr,
    output logic [7:0]  dm_wdat,
    input  logic [7:0]  dm_rdat,
    output logic        busy,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  LOAD_LAST = 8'(LOAD_LEN - 1);
    localparam logic [7:0]  RES_LAST  = 8'(RES_LEN - 1);
    localparam logic [7:0]  RES_BASE8 = 8'(RES_BASE);
    localparam logic [15:0] CYC_LAST  = 16'(MAX_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cyc_q, cyc_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            cyc_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cyc_d      = cyc_q;
        core_reset = 1'b1;
        mem_sel    = 1'b1;
        ld_ready   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 8'd0;
        dm_wen     = 1'b0;
        dm_addr    = 8'd0;
        dm_wdat    = 8'd0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = 8'd0;
                    cyc_d   = 16'd0;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                dm_addr  = idx_q;
                dm_wdat  = ld_data;
                dm_wen   = ld_valid;
                if (ld_valid) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == LOAD_LAST) begin
                        state_d = S_RUN;
                        idx_d   = 8'd0;
                    end
                end
            end
            S_RUN: begin
                core_reset = 1'b0;
                mem_sel    = 1'b0;
                if (core_done) begin
                    state_d = S_DRAIN;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                    if (cyc_q == CYC_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DRAIN: begin
                // Read address is held by idx, so a stalled byte stays put.
                dm_addr  = RES_BASE8 + idx_q;
                rd_valid = 1'b1;
                rd_data  = dm_rdat;
                if (rd_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (idx_q == RES_LAST) begin
                        state_d = S_DONE;
                        idx_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_LOAD) ||
                         (state_q == S_RUN)  ||
                         (state_q == S_DRAIN);
    assign timeout     = (state_q == S_ERR);
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: default instance for load/run/drain,
// a MAX_CYCLES=16 instance for the timeout path.
module tb_core_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        rd_ready;
    logic        core_done;

    logic        a_ld_ready, a_rd_valid, a_core_reset, a_mem_sel;
    logic        a_dm_wen, a_busy, a_timeout;
    logic [7:0]  a_rd_data, a_dm_addr, a_dm_wdat, a_dm_rdat;
    logic [15:0] a_cycle_count;

    logic        start2, ld_valid2, rd_ready2, core_done2;
    logic [7:0]  b_dm_rdat;
    logic        b_ld_ready, b_rd_valid, b_core_reset, b_mem_sel;
    logic        b_dm_wen, b_busy, b_timeout;
    logic [7:0]  b_rd_data, b_dm_addr, b_dm_wdat;
    logic [15:0] b_cycle_count;

    logic [7:0]  dm [256];
    logic [15:0] wq [$];
    logic [7:0]  rq [$];

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    logic acc;

    core_sequencer u_a (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(a_ld_ready),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_ready(rd_ready),
        .core_reset(a_core_reset), .core_done(core_done),
        .mem_sel(a_mem_sel), .dm_wen(a_dm_wen), .dm_addr(a_dm_addr),
        .dm_wdat(a_dm_wdat), .dm_rdat(a_dm_rdat), .busy(a_busy),
        .timeout(a_timeout), .cycle_count(a_cycle_count)
    );

    core_sequencer #(.MAX_CYCLES(16)) u_b (
        .clk(clk), .reset(reset), .start(start2),
        .ld_valid(ld_valid2), .ld_data(ld_data), .ld_ready(b_ld_ready),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(rd_ready2),
        .core_reset(b_core_reset), .core_done(core_done2),
        .mem_sel(b_mem_sel), .dm_wen(b_dm_wen), .dm_addr(b_dm_addr),
        .dm_wdat(b_dm_wdat), .dm_rdat(b_dm_rdat), .busy(b_busy),
        .timeout(b_timeout), .cycle_count(b_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result region is a fixed pattern; loads only touch 0..63.
    assign a_dm_rdat = (a_dm_addr >= 8'd64) ? (a_dm_addr ^ 8'h5A)
                                            : dm[a_dm_addr];
    assign b_dm_rdat = 8'h00;

    always @(posedge clk) begin
        if (a_dm_wen && a_mem_sel) begin
            dm[a_dm_addr] <= a_dm_wdat;
            wq.push_back({a_dm_addr, a_dm_wdat});
        end
        if (a_rd_valid && rd_ready) rq.push_back(a_rd_data);
    end

    typedef struct {
        logic [4:0]  in;
        int          n;
        logic [5:0]  ex;
        logic [15:0] cyc;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic edge_();
        acc = ld_valid && a_ld_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            load_cnt++;
            ld_data = 8'(load_cnt);
        end
    endtask

    task automatic cycle_();
        @(negedge clk);
        edge_();
    endtask

    task automatic begin_run();
        load_cnt = 0;
        ld_data  = 8'd0;
        wq.delete();
        rq.delete();
        start = 1'b1;
        cycle_();
        start = 1'b0;
    endtask

    task automatic check_queues(input string tag, input int nw);
        int bad;
        chk({tag, "_wr_count"}, wq.size(), nw);
        bad = 0;
        foreach (wq[i]) if (wq[i] !== {8'(i), 8'(i)}) bad++;
        chk({tag, "_wr_order"}, bad, 0);
        chk({tag, "_rd_count"}, rq.size(), 32);
        bad = 0;
        foreach (rq[i]) if (rq[i] !== (8'(64 + i) ^ 8'h5A)) bad++;
        chk({tag, "_rd_order"}, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc_n, run_at, last_acc, run_n;
        bit fin;
        // in = {reset, start, ld_valid, core_done, rd_ready}
        // ex = {core_reset, mem_sel, ld_ready, rd_valid, busy, timeout}
        tbl[0] = '{5'b00000,   2, 6'b110000, 16'd0};
        tbl[1] = '{5'b11000,   1, 6'b110000, 16'd0};
        tbl[2] = '{5'b10100,  64, 6'b111010, 16'd0};
        tbl[3] = '{5'b10000, 100, 6'b000010, 16'd99};
        tbl[4] = '{5'b10010,   1, 6'b000010, 16'd100};
        tbl[5] = '{5'b10001,  32, 6'b110110, 16'd100};
        tbl[6] = '{5'b10001,   2, 6'b110000, 16'd100};

        reset = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = 8'd0;
        rd_ready = 1'b0; core_done = 1'b0;
        start2 = 1'b0; ld_valid2 = 1'b0; rd_ready2 = 1'b0;
        core_done2 = 1'b0;

        // Nominal run
        for (int v = 0; v < 7; v++) begin
            for (int c = 0; c < tbl[v].n; c++) begin
                {reset, start, ld_valid, core_done, rd_ready} = tbl[v].in;
                @(negedge clk);
                if (c == tbl[v].n - 1) begin
                    chk($sformatf("vec%0d_ctl", v),
                        {a_core_reset, a_mem_sel, a_ld_ready,
                         a_rd_valid, a_busy, a_timeout}, tbl[v].ex);
                    chk($sformatf("vec%0d_cyc", v),
                        a_cycle_count, tbl[v].cyc);
                end
                edge_();
            end
        end
        check_queues("nominal", 64);

        // Load backpressure, immediate done, drain backpressure
        rd_ready = 1'b0;
        begin_run();
        acc_n = 0; run_at = -1; last_acc = -1;
        for (int c = 0; c < 300 && run_at < 0; c++) begin
            ld_valid = (c % 2 == 0);
            @(negedge clk);
            if (!a_core_reset) begin
                run_at = c;
            end else if (ld_valid && a_ld_ready) begin
                acc_n++;
                last_acc = c;
            end
            edge_();
        end
        ld_valid = 1'b0;
        chk("bp_run_seen", 32'(run_at >= 0), 1);
        chk("bp_accepts", acc_n, 64);
        chk("bp_run_next", run_at, last_acc + 1);
        core_done = 1'b1;
        cycle_();
        core_done = 1'b0;
        rd_ready = 1'b1;
        repeat (10) cycle_();
        rd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", a_rd_valid, 1);
            chk("stall_data", a_rd_data, 8'(74) ^ 8'h5A);
            chk("stall_addr", a_dm_addr, 8'd74);
            edge_();
        end
        rd_ready = 1'b1;
        fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (!a_busy) fin = 1;
            else edge_();
        end
        chk("bp_drain_end", 32'(fin), 1);
        chk("bp_cycles", a_cycle_count, 16'd1);
        check_queues("bp", 64);
        edge_();

        // start pulsed in RUN is ignored, start in DONE restarts
        begin_run();
        ld_valid = 1'b1;
        repeat (64) cycle_();
        ld_valid = 1'b0;
        @(negedge clk);
        chk("run_first", {a_core_reset, a_mem_sel}, 2'b00);
        edge_();
        cycle_();
        start = 1'b1;
        cycle_();
        start = 1'b0;
        @(negedge clk);
        chk("run_ign_start", {a_core_reset, a_ld_ready, a_busy}, 3'b001);
        chk("run_cyc4", a_cycle_count, 16'd3);
        edge_();
        repeat (6) cycle_();
        core_done = 1'b1;
        cycle_();
        core_done = 1'b0;
        @(negedge clk);
        chk("drain_first", a_rd_valid, 1);
        edge_();
        repeat (31) cycle_();
        @(negedge clk);
        chk("done_ctl", {a_busy, a_timeout, a_rd_valid}, 3'b000);
        chk("done_cyc", a_cycle_count, 16'd10);
        edge_();
        start = 1'b1;
        cycle_();
        start = 1'b0;
        load_cnt = 0;
        ld_data = 8'd0;
        @(negedge clk);
        chk("restart_ready", a_ld_ready, 1);
        chk("restart_cyc", a_cycle_count, 16'd0);

        // Reset in the middle of a load
        ld_valid = 1'b1;
        edge_();
        repeat (9) cycle_();
        ld_valid = 1'b0;
        reset = 1'b0;
        cycle_();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ctl", {a_core_reset, a_mem_sel, a_ld_ready, a_rd_valid,
                        a_dm_wen, a_busy, a_timeout}, 7'b1100000);
        chk("rst_addr", {a_dm_addr, a_dm_wdat}, 16'd0);
        chk("rst_cyc", a_cycle_count, 16'd0);
        chk("rst_b_ctl", {b_core_reset, b_mem_sel, b_ld_ready,
                          b_rd_valid, b_dm_wen, b_busy}, 6'b110000);
        chk("rst_b_addr", {b_dm_addr, b_dm_wdat}, 16'd0);
        edge_();
        begin_run();
        ld_valid = 1'b1;
        @(negedge clk);
        chk("reload_addr0", a_dm_addr, 8'd0);
        edge_();
        repeat (2) cycle_();
        ld_valid = 1'b0;
        chk("reload_count", wq.size(), 3);
        chk("reload_first", wq.size() > 0 ? 32'(wq[0]) : 32'hFFFF, 0);
        reset = 1'b0;
        cycle_();
        reset = 1'b1;

        // Timeout on the short-budget instance
        start2 = 1'b1;
        cycle_();
        start2 = 1'b0;
        ld_valid2 = 1'b1;
        repeat (64) cycle_();
        ld_valid2 = 1'b0;
        run_n = 0;
        fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (b_timeout) begin
                fin = 1;
            end else begin
                if (!b_core_reset) run_n++;
                edge_();
            end
        end
        chk("to_seen", 32'(fin), 1);
        chk("to_run_cycles", run_n, 16);
        chk("to_cyc", b_cycle_count, 16'd16);
        chk("to_ctl", {b_core_reset, b_mem_sel, b_busy, b_rd_valid,
                       b_ld_ready, b_dm_wen}, 6'b110000);
        chk("to_rd_data", b_rd_data, 8'd0);
        edge_();
        start2 = 1'b1;
        cycle_();
        start2 = 1'b0;
        @(negedge clk);
        chk("to_restart", {b_ld_ready, b_timeout}, 2'b10);
        chk("to_restart_cyc", b_cycle_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run-control stage that sits directly upstream of the processor top level and owns its data-memory port whenever the core is not executing. On `start` it holds the core in reset and streams an input image into data memory. It then releases the core and counts execution cycles until the core's `done` rises or a timeout fires. Finally it streams the result region of data memory back out through a valid/ready port.

## Interface
Parameters:
- LOAD_LEN, 64: bytes written to DM addresses 0..LOAD_LEN-1 per run (1..255)
- RES_BASE, 64: first DM address of the result region
- RES_LEN, 32: result bytes streamed out (1..256-RES_BASE)
- MAX_CYCLES, 4096: RUN-cycle budget before timeout (2..65535)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE, DONE, ERR
- ld_valid  in  1  load byte valid
- ld_data  in  8  load byte
- ld_ready  out  1  sequencer accepts a load byte
- rd_valid  out  1  result byte valid
- rd_data  out  8  result byte
- rd_ready  in  1  consumer accepts result byte
- core_reset  out  1  active-high reset driven to the core
- core_done  in  1  core's level `done` flag
- mem_sel  out  1  1 = sequencer drives the DM port, 0 = core drives it
- dm_wen  out  1  DM write enable (sequencer side)
- dm_addr  out  8  DM address (sequencer side)
- dm_wdat  out  8  DM write data
- dm_rdat  in  8  DM read data, combinational read of dm_addr
- busy  out  1  state is LOAD, RUN or DRAIN
- timeout  out  1  state is ERR
- cycle_count  out  16  RUN cycles elapsed in the current or last run

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE, ERR. All outputs are combinational from state and counters, except `cycle_count`, which is a register.
- IDLE: core_reset=1, mem_sel=1, dm_wen=0. start=1 -> LOAD, with idx<=0 and cycle_count<=0.
- LOAD: ld_ready=1, dm_addr=idx, dm_wdat=ld_data, dm_wen=ld_valid, core_reset=1.
  - A byte is accepted on ld_valid&&ld_ready; idx increments.
  - Accepting the byte at idx==LOAD_LEN-1 -> RUN, idx<=0.
- RUN: core_reset=0, mem_sel=0, dm_wen=0, ld_ready=0.
  - core_done=1 -> DRAIN; cycle_count holds.
  - core_done=0: cycle_count increments. If cycle_count==MAX_CYCLES-1 before the increment -> ERR.
- DRAIN: core_reset=1, mem_sel=1, dm_addr=RES_BASE+idx (8-bit wrap), rd_valid=1, rd_data=dm_rdat.
  - On rd_valid&&rd_ready, idx increments.
  - Handshake at idx==RES_LEN-1 -> DONE.
  - rd_data stays stable while rd_ready=0.
- DONE / ERR: core_reset=1, mem_sel=1, all stream outputs low. start=1 -> LOAD with counters cleared; cycle_count holds until then.
- `start` is ignored in LOAD, RUN and DRAIN.
- ld_valid outside LOAD is ignored; no write occurs.
- idx is 8 bits; dm_addr arithmetic wraps mod 256.

## Timing
- Reset (reset=0 at a clock edge): state IDLE, idx=0, cycle_count=0, core_reset=1, mem_sel=1, ld_ready=0, rd_valid=0, dm_wen=0, dm_addr=0, dm_wdat=0, busy=0, timeout=0. Reset applies in any state, including mid-LOAD and mid-DRAIN; partial images are abandoned.
- start at edge k -> LOAD from cycle k+1; ld_ready is high in cycle k+1.
- Loading takes at minimum LOAD_LEN cycles, at one byte per cycle with back-to-back ld_valid.
- First RUN cycle: core_reset=0 and mem_sel=0. The core leaves reset at the next edge.
- If core_done is first seen high in RUN cycle N+1, the final cycle_count is N.
- Timeout: after MAX_CYCLES done-free RUN cycles, state is ERR and cycle_count=MAX_CYCLES.
- Drain takes at minimum RES_LEN cycles. The first rd_valid appears in the cycle after done is sampled.

## Test plan
- Nominal run: start, 64 bytes 0x00..0x3F with ld_valid held; core model raises done after 100 RUN cycles; rd_ready=1.
  - Required: DM[0..63] written in order; 32 result bytes read from DM[64..95] in order; cycle_count=100; DONE; timeout=0.
- Load backpressure: toggle ld_valid every other cycle.
  - Required: exactly 64 writes, no address skipped; RUN entered after the 64th accept.
- Drain backpressure: hold rd_ready=0 for 5 cycles mid-drain.
  - Required: rd_data and dm_addr stable throughout; no byte lost or duplicated.
- Timeout: MAX_CYCLES=16, core_done held at 0.
  - Required: ERR after 16 RUN cycles, timeout=1, cycle_count=16, core_reset=1, mem_sel=1.
- Reset mid-LOAD at byte 10, then start again.
  - Required: IDLE with all outputs at reset values; the new load restarts at address 0.
- start pulsed during RUN, then again in DONE.
  - Required: the RUN pulse is ignored; the DONE pulse enters LOAD with cycle_count=0.
